rom_image_loader: RTL and testbench

//   Writer end of the 16x8 lookup store: loads a full 16-byte image from a

---
 rtl/rom_image_loader_if.sv | 22 ++
 rtl/rom_image_loader.sv | 106 ++++++++++
 tb/tb_rom_image_loader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rom_image_loader_if.sv
// rtl/rom_image_loader_if.sv - byte-stream write port and combinational read port of the image loader
// The master drives the stream and the read address; the slave (loader) answers with ready and read data.
interface rom_image_loader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output in_valid, in_data, rd_addr,
      input  in_ready, rd_data
   );

   modport slave (
      input  in_valid, in_data, rd_addr,
      output in_ready, rd_data
   );
endinterface

// File: rtl/rom_image_loader.sv
// rtl/rom_image_loader.sv - loads a 2**ADDR_W byte image from a stream into a table with a combinational read port
// Power-up/reset contents are the i*0x11 pattern so consumers see a known table before any load.
module rom_image_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   rom_image_loader_if.slave   bus,
   output logic                busy_o,
   output logic                done_o,
   output logic [ADDR_W:0]     load_count_o,
   output logic [DATA_W-1:0]   checksum_o,
   output logic                overflow_err_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [DATA_W-1:0]   cksum_q, cksum_d;
   logic                err_q, err_d;
   logic                wr_en;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         cksum_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         cksum_q  <= cksum_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      cksum_d  = cksum_q;
      err_d    = err_q;
      wr_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
               cksum_d  = '0;
               err_d    = 1'b0;
            end
         end
         S_LOAD: begin
            // start is deliberately not decoded here: a load always runs to completion
            if (bus.in_valid) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               count_d  = count_q + (ADDR_W + 1)'(1);
               cksum_d  = cksum_q + bus.in_data;
               if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start_i) begin
               state_d  = S_LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
               cksum_d  = '0;
               err_d    = 1'b0;
            end else if (bus.in_valid) begin
               err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= DATA_W'(i * 'h11);
         end
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign bus.rd_data    = mem_q[bus.rd_addr];
   assign bus.in_ready   = (state_q == S_LOAD);
   assign busy_o         = (state_q == S_LOAD);
   assign done_o         = (state_q == S_DONE);
   assign load_count_o   = count_q;
   assign checksum_o     = cksum_q;
   assign overflow_err_o = err_q;
endmodule

// File: tb/tb_rom_image_loader.sv
// tb/tb_rom_image_loader.sv - directed self-checking bench for rom_image_loader
// Inputs change 1ns after the rising edge; outputs are sampled there as well.
module tb_rom_image_loader;
   logic       clk;
   logic       rst_n;
   logic       start_i;
   logic       busy_o;
   logic       done_o;
   logic [4:0] load_count_o;
   logic [7:0] checksum_o;
   logic       overflow_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   rom_image_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   rom_image_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .bus            (bus),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .load_count_o   (load_count_o),
      .checksum_o     (checksum_o),
      .overflow_err_o (overflow_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
      bus.rd_addr = addr;
      #1;
      check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Streams base+0 .. base+15; gap inserts a bubble every other cycle,
   // start_at (0..15) raises start together with that beat, chk_old verifies
   // read-before-write on the default table.
   task automatic load_image(input logic [7:0] base, input bit gap,
                             input int start_at, input bit chk_old);
      int  idx = 0;
      int  cyc = 0;
      bit  acc;
      while (idx < 16 && cyc < 100) begin
         bus.in_valid = gap ? (cyc % 2 == 0) : 1'b1;
         bus.in_data  = base + 8'(idx);
         start_i      = (idx == start_at) && bus.in_valid;
         if (chk_old && bus.in_valid && idx == 3) begin
            read_chk("read_old_before_edge", 4'd3, 8'h33);
         end
         acc = bus.in_valid && bus.in_ready;
         tick();
         start_i = 1'b0;
         if (acc) begin
            idx++;
            if (idx == start_at + 1) begin
               check("start_ignored_count", {27'd0, load_count_o}, start_at + 1);
               check("start_ignored_busy", {31'd0, busy_o}, 1);
            end
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("load_beats", idx, 16);
   endtask

   task automatic check_final_a0();
      check("done", {31'd0, done_o}, 1);
      check("busy_after", {31'd0, busy_o}, 0);
      check("in_ready_after", {31'd0, bus.in_ready}, 0);
      check("load_count", {27'd0, load_count_o}, 16);
      check("checksum", {24'd0, checksum_o}, 32'h78);
      read_chk("rd_addr3", 4'd3, 8'hA3);
      read_chk("rd_addr15", 4'd15, 8'hAF);
   endtask

   initial begin
      rst_n        = 1'b0;
      start_i      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.rd_addr  = 4'd0;
      #12;
      rst_n = 1'b1;
      tick();

      // 1: reset state and default table
      read_chk("rst_rd5", 4'd5, 8'h55);
      read_chk("rst_rd15", 4'd15, 8'hFF);
      check("rst_busy", {31'd0, busy_o}, 0);
      check("rst_done", {31'd0, done_o}, 0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 0);
      check("rst_err", {31'd0, overflow_err_o}, 0);
      check("rst_count", {27'd0, load_count_o}, 0);
      check("rst_cksum", {24'd0, checksum_o}, 0);

      // data offered in IDLE is dropped silently
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      tick();
      bus.in_valid = 1'b0;
      check("idle_err", {31'd0, overflow_err_o}, 0);
      check("idle_count", {27'd0, load_count_o}, 0);
      read_chk("idle_rd0", 4'd0, 8'h00);

      // 2: back-to-back load
      pulse_start();
      check("load_busy", {31'd0, busy_o}, 1);
      check("load_in_ready", {31'd0, bus.in_ready}, 1);
      load_image(8'hA0, 1'b0, 99, 1'b1);
      check_final_a0();
      tick();
      check("count_hold", {27'd0, load_count_o}, 16);

      // 4: overflow in DONE, then restart with in_valid still high
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      tick();
      check("ovf_err", {31'd0, overflow_err_o}, 1);
      check("ovf_count", {27'd0, load_count_o}, 16);
      read_chk("ovf_rd0", 4'd0, 8'hA0);
      start_i = 1'b1;
      tick();
      start_i      = 1'b0;
      bus.in_valid = 1'b0;
      check("restart_err", {31'd0, overflow_err_o}, 0);
      check("restart_busy", {31'd0, busy_o}, 1);
      check("restart_count", {27'd0, load_count_o}, 0);
      check("restart_cksum", {24'd0, checksum_o}, 0);

      // 3: same image with bubbles
      load_image(8'hA0, 1'b1, 99, 1'b0);
      check_final_a0();
      repeat (3) tick();
      check("gap_count_hold", {27'd0, load_count_o}, 16);

      // 5: reset after 7 accepted beats
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h30 + 8'(i);
         tick();
      end
      bus.in_valid = 1'b0;
      check("mid_count", {27'd0, load_count_o}, 7);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", {31'd0, busy_o}, 0);
      check("mrst_done", {31'd0, done_o}, 0);
      check("mrst_in_ready", {31'd0, bus.in_ready}, 0);
      check("mrst_count", {27'd0, load_count_o}, 0);
      check("mrst_cksum", {24'd0, checksum_o}, 0);
      read_chk("mrst_rd2", 4'd2, 8'h22);
      read_chk("mrst_rd6", 4'd6, 8'h66);
      tick();
      rst_n = 1'b1;
      tick();
      check("mrst_idle", {31'd0, busy_o | done_o}, 0);
      pulse_start();
      load_image(8'hA0, 1'b0, 99, 1'b1);
      check_final_a0();

      // 6: start during LOAD alongside beat 4 is ignored
      pulse_start();
      load_image(8'hA0, 1'b0, 4, 1'b0);
      check_final_a0();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
